// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, runs one outstanding word fetch at a time over a
// req/ack handshake, and buffers {pc, instr} pairs in a DEPTH-entry FIFO.
// A redirect flushes the FIFO and discards any response still in flight.
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
module if_fetch_queue #(
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_instr,
    output logic [DWIDTH-1:0] out_pc,
    input  logic              out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DWIDTH-1:0] PC_STEP  = DWIDTH'(4);

    logic              req_reg, req_next;
    logic [DWIDTH-1:0] addr_reg, addr_next;
    logic [DWIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic              drop_reg, drop_next;

    logic [DWIDTH-1:0] slot_pc_reg    [DEPTH];
    logic [DWIDTH-1:0] slot_instr_reg [DEPTH];
    logic [DEPTH-1:0]  slot_wr_en;

    logic              ack_fire;
    logic              still_pending;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] redirect_target;
    logic              redirect_low_unused;

    // Handshake decode: an ack only counts while a request is up; a response
    // is kept only if it is not marked for dropping and no redirect lands now.
    assign ack_fire        = req_reg && imem_ack;
    assign still_pending   = req_reg && !imem_ack;
    assign push            = ack_fire && !drop_reg && !redirect_valid;
    assign pop             = out_valid && out_ready && !redirect_valid;
    assign redirect_target = {redirect_pc[DWIDTH-1:2], 2'b00};
    assign redirect_low_unused = ^redirect_pc[1:0];

    // Head of the FIFO drives decode directly
    assign out_valid = (count_reg != '0);
    assign out_pc    = slot_pc_reg[rd_ptr_reg];
    assign out_instr = slot_instr_reg[rd_ptr_reg];
    assign imem_req  = req_reg;
    assign imem_addr = addr_reg;

    // Per-slot write enables: only the slot under wr_ptr takes a push
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_en
            assign slot_wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // FIFO occupancy, pointers and fetch PC; redirect overrides push/pop
    always_comb begin
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            fetch_pc_next = redirect_target;
        end else begin
            if (push) begin
                wr_ptr_next   = wr_ptr_reg + PTR_ONE;
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    // Request issue: hold an unanswered request with its address; otherwise
    // start a new one only if a FIFO slot is guaranteed for its response
    always_comb begin
        req_next  = 1'b0;
        addr_next = addr_reg;
        if (still_pending) begin
            req_next = 1'b1;
        end else if (count_next < CNT_FULL) begin
            req_next  = 1'b1;
            addr_next = fetch_pc_next;
        end
    end

    // A redirect during an unanswered request marks that response for discard;
    // the mark survives further redirects until the ack arrives
    assign drop_next = still_pending && (drop_reg || redirect_valid);

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg      <= 1'b0;
            addr_reg     <= RESET_PC;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            drop_reg     <= 1'b0;
        end else begin
            req_reg      <= req_next;
            addr_reg     <= addr_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            drop_reg     <= drop_next;
        end
    end

    // FIFO storage: capture {address, instruction} of an accepted response
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_wr_en[i]) begin
                slot_pc_reg[i]    <= addr_reg;
                slot_instr_reg[i] <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_flush_reg;
    logic [31:0] flush_amount;

    // A redirect throws away the buffered entries plus the in-flight
    // response, unless that response was already counted by an earlier redirect
    assign flush_amount = redirect_valid
                        ? (32'(count_reg) + {31'b0, req_reg && !drop_reg})
                        : 32'd0;

    // Free-running, wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            perf_fetch_reg <= perf_fetch_reg + {31'b0, push};
            perf_flush_reg <= perf_flush_reg + flush_amount;
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_flush_cnt = perf_flush_reg;
`endif

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage placed between the instruction memory and the decode stage of the 5-stage pipeline. Owns the fetch PC and issues word fetches over a req/ack handshake that tolerates variable latency. Buffers fetched {pc, instr} pairs in a small FIFO that the IF/ID register drains. Handles redirects from branch/jump resolution by flushing the FIFO and discarding any response still in flight.

Parameters:
DWIDTH, 32, data/address width
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
imem_req  output  1  fetch request; held until imem_ack
imem_addr  output  DWIDTH  fetch address, word aligned, stable while imem_req=1
imem_ack  input  1  response valid this cycle (ack while req=0 is ignored)
imem_rdata  input  DWIDTH  fetched instruction, valid with imem_ack
redirect_valid  input  1  branch/jump taken; reload fetch PC
redirect_pc  input  DWIDTH  new fetch PC; bits [1:0] forced to 0
out_valid  output  1  FIFO head valid (count!=0)
out_instr  output  DWIDTH  head instruction
out_pc  output  DWIDTH  head instruction address
out_ready  input  1  decode accepts head (0 during hazard stall)

Behaviour:
- Reset (registered outputs): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, rd/wr ptr=0, drop=0, out_valid=0.
- Storage: DEPTH-entry circular FIFO of {pc,instr}; wr_ptr/rd_ptr log2(DEPTH) bits wrapping naturally; count 0..DEPTH.
- out_* driven combinationally from head; out_instr/out_pc don't-care when out_valid=0.
- Dequeue: out_valid && out_ready -> rd_ptr+1, count-1.
- Max one request outstanding. imem_req registered; set next cycle when not pending and (count_next + 0) < DEPTH, i.e. a slot is guaranteed for the response.
- Handshake: while imem_req=1, imem_addr constant. On imem_ack: imem_req cleared unless a new request is issued (back-to-back allowed: req stays 1, addr advances to fetch_pc+4 same edge if space).
- Push on ack (drop=0, no redirect this cycle): entry {imem_addr, imem_rdata}, wr_ptr+1, count+1, fetch_pc += 4 (wraps mod 2^DWIDTH).
- Simultaneous push+pop: count unchanged, both pointers advance. Full (count=DEPTH): no new req; a full FIFO never sees a push.
- Redirect (highest priority except rst): count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[DWIDTH-1:2],2'b00}, any pop this cycle ignored (out_valid=0 next cycle).
  - No request pending: next cycle imem_req=1, imem_addr=new PC.
  - Request pending, no ack this cycle: drop=1; req stays with old addr until ack; that ack is discarded (no push), drop cleared, new req issued next cycle.
  - Ack in same cycle as redirect: response discarded, new req next cycle.
  - Redirect while drop=1: fetch_pc updated only; still one response dropped.
- Latency: redirect -> first out_valid >= 2 cycles + memory latency; zero-latency memory (ack same cycle as req) delivers 1 instr/cycle steady state.
- rst mid-operation: all state reset at the edge; pending transaction abandoned (memory must tolerate req dropping).

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetch_cnt[31:0] (pushes) and perf_flush_cnt[31:0] (entries flushed + responses dropped by redirects), both reset to 0, wrapping. Without the macro the ports and counters do not exist; behaviour otherwise identical.

Test Plan:
- Reset, 0-latency imem, out_ready=1 -> addrs 0x0,0x4,0x8... issued; out_pc sequence 0x0,0x4,0x8 one per cycle after 2-cycle fill.
- out_ready=0 for 10 cycles, 1-cycle latency -> exactly 4 entries (pc 0x0..0xC), imem_req=0 while full; release -> drains in order, fetch resumes at 0x10.
- Redirect to 0x0000_0103 with FIFO holding 3 entries, no pending req -> out_valid=0 next cycle; next imem_addr=0x100; next out_pc=0x100.
- Redirect to 0x200 while req to 0x14 pending (3-cycle latency) -> req holds 0x14 until ack, response discarded, next req 0x200; no entry with pc 0x14 appears.
- Redirect and ack in same cycle, plus pop same cycle -> no push, count=0, next req=redirect_pc; with FETCH_PERF_EN perf_flush_cnt increments by flushed entries+1.
- Assert rst with pending request and 2 entries -> next cycle imem_req=0, out_valid=0, imem_addr=RESET_PC; fetch restarts from RESET_PC.
